sdram_line_xfer: RTL and testbench
==================================

// Module: sdram_line_xfer
// PURPOSE
//  Moves one 128-bit cache way-line (4 x 32b words) between the 2-way cache and the SDRAM controller.
//  Writebacks are serialized into 8 x 16b SDRAM beats; refills are assembled from 8 x 16b beats.
//  Sits directly below the cache controller's ACCESS_READ/ACCESS_WRITE path and drives the SDRAM controller.
// PARAMETERS
//  BURST_LEN  8    16b beats per line (sdram_access_len); must be 8
//  TIMEOUT    255  max idle cycles waiting for ack/beat before aborting with rsp_err
// PORTS
//  clk              in   1    system clock
//  rst_n            in   1    asynchronous active-low reset
//  req_valid        in   1    cache requests a line transfer
//  req_ready        out  1    high only in IDLE; transfer accepted on req_valid&&req_ready
//  req_write        in   1    1 = writeback (cache->SDRAM), 0 = refill (SDRAM->cache)
//  req_addr         in   32   byte address of line (cache_addr_t); bits[3:0] ignored
//  req_wdata        in   128  line data; data0w0 layout, word 0 in [127:96]
//  rsp_valid        out  1    one-cycle pulse: transfer finished
//  rsp_err          out  1    qualifies rsp_valid: transfer aborted by timeout
//  rsp_rdata        out  128  assembled refill line; valid with rsp_valid when req_write was 0
//  sdram_addr       out  24   SDRAM 16b-word address = {req_addr[24:4], 3'b000}
//  sdram_wr_req     out  1    write burst command, held until sdram_ack
//  sdram_rd_req     out  1    read burst command, held until sdram_ack
//  sdram_ack        in   1    controller accepted the pending command
//  sdram_wr_data_req in  1    controller consumes sdram_wr_data this cycle
//  sdram_wr_data    out  16   current write beat
//  sdram_rd_valid   in   1    sdram_rd_data carries a read beat this cycle
//  sdram_rd_data    in   16   read beat
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, sdram_addr=0,
//   sdram_wr_req=0, sdram_rd_req=0, sdram_wr_data=0; beat counter and timeout counter = 0.
//  Beat order: beat i (0..7) = line[127-16*i -: 16]; upper half of each 32b word goes first (be_w0 half).
//  FSM: IDLE -> WR_CMD (req_write=1) | RD_CMD (req_write=0) on acceptance; latch addr, wdata, write flag.
//   WR_CMD: sdram_wr_req=1; on sdram_ack -> WR_DATA (req drops the cycle after ack).
//   WR_DATA: sdram_wr_data = current beat (registered, valid from state entry);
//    each sdram_wr_data_req advances beat; the 8th consumed beat -> DONE.
//   RD_CMD: sdram_rd_req=1; on sdram_ack -> RD_DATA.
//   RD_DATA: each sdram_rd_valid writes sdram_rd_data into beat slot; the 8th beat -> DONE.
//   DONE: rsp_valid=1 for exactly one cycle, then IDLE (req_ready=1 next cycle). No back-to-back
//    acceptance in DONE; minimum request spacing = burst + 3 cycles.
//  rsp_rdata updates only on a completed refill; holds its value through writebacks and errors.
//  Timeout: counter clears on entry to each non-IDLE state and on every ack/beat; when it reaches
//   TIMEOUT, drop sdram_*_req, go to DONE with rsp_err=1 (rsp_rdata not updated).
//  Ignored inputs: sdram_rd_valid outside RD_DATA (including the ack cycle), beats beyond the 8th,
//   sdram_wr_data_req outside WR_DATA, sdram_ack outside *_CMD. req_* ignored while req_ready=0.
//  Wait states: any number of idle cycles between beats is legal (below TIMEOUT).
//  Reset mid-transfer: immediate return to reset values; the in-flight transfer is dropped without rsp.
// TESTING
//  1 Writeback addr 0x0000_1230, wdata 0x0011_2233_4455_6677_8899_AABB_CCDD_EEFF, ack after 2 cycles,
//    data_req every cycle -> sdram_addr 0x000918, beats 0011,2233,...,EEFF in order, one rsp_valid, rsp_err=0.
//  2 Refill addr 0x0100_0040, beats 0xA000..0xA007 with 1-3 gap cycles -> sdram_addr 0x800020,
//    rsp_rdata 0xA000_A001_..._A007, rsp_valid pulse 1 cycle.
//  3 rd_valid asserted in the ack cycle and a 9th beat after DONE -> both ignored, rsp_rdata unchanged by them.
//  4 Refill with sdram_ack withheld for TIMEOUT cycles -> rd_req drops, rsp_valid=1 with rsp_err=1,
//    rsp_rdata holds the previous line.
//  5 rst_n low after beat 3 of a writeback -> all outputs to reset values asynchronously; next request
//    after release completes normally.
//  6 Two back-to-back requests with req_valid held -> second accepted only the cycle after rsp_valid.

Source files
------------

// File: rtl/sdram_line_xfer_if.sv
// Cache-side request/response and SDRAM-controller burst signals of the line mover.
interface sdram_line_xfer_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_err;
  logic [127:0] rsp_rdata;
  logic [23:0]  sdram_addr;
  logic         sdram_wr_req;
  logic         sdram_rd_req;
  logic         sdram_ack;
  logic         sdram_wr_data_req;
  logic [15:0]  sdram_wr_data;
  logic         sdram_rd_valid;
  logic [15:0]  sdram_rd_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output sdram_ack, sdram_wr_data_req, sdram_rd_valid, sdram_rd_data,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  sdram_addr, sdram_wr_req, sdram_rd_req, sdram_wr_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  sdram_ack, sdram_wr_data_req, sdram_rd_valid, sdram_rd_data,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output sdram_addr, sdram_wr_req, sdram_rd_req, sdram_wr_data
  );
endinterface

// File: rtl/sdram_line_xfer.sv
// Moves one 128b cache line to/from the SDRAM controller as 8 x 16b beats,
// most significant half-word first, with an idle-cycle timeout on every wait.
module sdram_line_xfer #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  sdram_line_xfer_if.slave bus
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [127:0]  line_q;
  logic          err_q;
  logic          accept, busy, cmd_ack, wr_beat, rd_beat, progress;
  logic          last_beat, tmo_hit, abort;
  logic          unused_addr_bits;

  // Beat idx is line[127-16*idx -: 16]; shifting it to the top avoids a variable part-select.
  function automatic logic [15:0] beat_of(input logic [127:0] line, input logic [BW-1:0] idx);
    logic [127:0] sh;
    sh = line << {idx, 4'b0000};
    return sh[127:112];
  endfunction

  assign unused_addr_bits = ^{bus.req_addr[31:25], bus.req_addr[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    accept    = (state_q == IDLE) && bus.req_valid;
    busy      = (state_q != IDLE) && (state_q != DONE);
    cmd_ack   = ((state_q == WR_CMD) || (state_q == RD_CMD)) && bus.sdram_ack;
    wr_beat   = (state_q == WR_DATA) && bus.sdram_wr_data_req;
    rd_beat   = (state_q == RD_DATA) && bus.sdram_rd_valid;
    progress  = cmd_ack || wr_beat || rd_beat;
    last_beat = (beat_cnt == BEAT_LAST);
    tmo_hit   = (tmo_cnt == TMO_MAX);
    abort     = busy && !progress && tmo_hit;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.req_write ? WR_CMD : RD_CMD;
      WR_CMD:  if (cmd_ack) state_d = WR_DATA;
      RD_CMD:  if (cmd_ack) state_d = RD_DATA;
      WR_DATA: if (wr_beat && last_beat) state_d = DONE;
      RD_DATA: if (rd_beat && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = DONE;
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == DONE);
  assign bus.rsp_err      = (state_q == DONE) && err_q;
  assign bus.sdram_wr_req = (state_q == WR_CMD);
  assign bus.sdram_rd_req = (state_q == RD_CMD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt          <= '0;
      tmo_cnt           <= '0;
      line_q            <= '0;
      err_q             <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.sdram_addr    <= '0;
      bus.sdram_wr_data <= '0;
    end else begin
      if (accept) begin
        beat_cnt       <= '0;
        err_q          <= 1'b0;
        line_q         <= bus.req_wdata;
        bus.sdram_addr <= {bus.req_addr[24:4], 3'b000};
        if (bus.req_write) bus.sdram_wr_data <= beat_of(bus.req_wdata, '0);
      end
      if (wr_beat || rd_beat) beat_cnt <= beat_cnt + BW'(1);
      if (abort) err_q <= 1'b1;
      if (!busy || progress) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + TW'(1);
      // Present the next beat as soon as the current one is consumed.
      if (wr_beat && !last_beat) bus.sdram_wr_data <= beat_of(line_q, beat_cnt + BW'(1));
      if (rd_beat) begin
        line_q[{~beat_cnt, 4'b0000} +: 16] <= bus.sdram_rd_data;
        if (last_beat) bus.rsp_rdata <= {line_q[127:16], bus.sdram_rd_data};
      end
    end
  end
endmodule

// File: tb/tb_sdram_line_xfer.sv
// Directed bench for sdram_line_xfer: writeback, refill, ignored inputs, timeout,
// mid-transfer reset and request spacing.
module tb_sdram_line_xfer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] LINE_A = 128'hA000_A001_A002_A003_A004_A005_A006_A007;
  localparam logic [127:0] LINE_B = 128'hB000_B001_B002_B003_B004_B005_B006_B007;
  localparam logic [127:0] LINE_C = 128'hC000_C001_C002_C003_C004_C005_C006_C007;

  always #5 clk = ~clk;

  sdram_line_xfer_if bus();

  sdram_line_xfer #(.BURST_LEN(8), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.sdram_ack = 1'b0; bus.sdram_wr_data_req = 1'b0;
    bus.sdram_rd_valid = 1'b0; bus.sdram_rd_data = '0;
    step(); step();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== 128'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_checks++; if (bus.sdram_addr !== 24'h0) begin n_fail++; $display("FAIL rst_sdram_addr: got %h want 0", bus.sdram_addr); end
    n_checks++; if (bus.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_wr_req: got %b want 0", bus.sdram_wr_req); end
    n_checks++; if (bus.sdram_rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_rd_req: got %b want 0", bus.sdram_rd_req); end
    n_checks++; if (bus.sdram_wr_data !== 16'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", bus.sdram_wr_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_writeback();
    logic [15:0] exp_beat [8];
    int pulses = 0;
    exp_beat = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_1230;
    bus.req_wdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (bus.sdram_wr_req !== 1'b1) begin n_fail++; $display("FAIL wb_wr_req: got %b want 1", bus.sdram_wr_req); end
    n_checks++; if (bus.sdram_addr !== 24'h000918) begin n_fail++; $display("FAIL wb_addr: got %h want 000918", bus.sdram_addr); end
    step(); step();
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    n_checks++; if (bus.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL wb_wr_req_drop: got %b want 0", bus.sdram_wr_req); end
    bus.sdram_wr_data_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.sdram_wr_data !== exp_beat[i]) begin n_fail++; $display("FAIL wb_beat%0d: got %h want %h", i, bus.sdram_wr_data, exp_beat[i]); end
      if (bus.rsp_valid) pulses++;
      step();
    end
    bus.sdram_wr_data_req = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wb_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wb_rsp_err: got %b want 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== 128'h0) begin n_fail++; $display("FAIL wb_rdata_hold: got %h want 0", bus.rsp_rdata); end
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) pulses++;
      step();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL wb_rsp_pulses: got %0d want 1", pulses); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL wb_ready_after: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_refill();
    int pulses = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0100_0040;
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (bus.sdram_rd_req !== 1'b1) begin n_fail++; $display("FAIL rf_rd_req: got %b want 1", bus.sdram_rd_req); end
    n_checks++; if (bus.sdram_addr !== 24'h800020) begin n_fail++; $display("FAIL rf_addr: got %h want 800020", bus.sdram_addr); end
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    n_checks++; if (bus.sdram_rd_req !== 1'b0) begin n_fail++; $display("FAIL rf_rd_req_drop: got %b want 0", bus.sdram_rd_req); end
    for (int i = 0; i < 8; i++) begin
      repeat (1 + i % 3) step();
      bus.sdram_rd_valid = 1'b1;
      bus.sdram_rd_data  = 16'(16'hA000 + i);
      step();
      bus.sdram_rd_valid = 1'b0;
      if (i < 7 && bus.rsp_valid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rf_early_rsp: got %0d want 0", pulses); end
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rf_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rf_rsp_err: got %b want 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== LINE_A) begin n_fail++; $display("FAIL rf_rdata: got %h want %h", bus.rsp_rdata, LINE_A); end
    step();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rf_rsp_one_cycle: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_ignored();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0080;
    step();
    bus.req_valid = 1'b0;
    bus.sdram_ack = 1'b1; bus.sdram_rd_valid = 1'b1; bus.sdram_rd_data = 16'hDEAD;
    step();
    bus.sdram_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sdram_rd_data = 16'(16'hB000 + i);
      step();
    end
    bus.sdram_rd_data = 16'hBEEF;
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ig_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== LINE_B) begin n_fail++; $display("FAIL ig_rdata: got %h want %h", bus.rsp_rdata, LINE_B); end
    step();
    bus.sdram_ack = 1'b1; bus.sdram_wr_data_req = 1'b1;
    step();
    bus.sdram_rd_valid = 1'b0; bus.sdram_ack = 1'b0; bus.sdram_wr_data_req = 1'b0;
    n_checks++; if (bus.rsp_rdata !== LINE_B) begin n_fail++; $display("FAIL ig_rdata_9th: got %h want %h", bus.rsp_rdata, LINE_B); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ig_idle_ready: got %b want 1", bus.req_ready); end
    n_checks++; if ({bus.sdram_wr_req, bus.sdram_rd_req} !== 2'b00) begin n_fail++; $display("FAIL ig_idle_reqs: got %b want 00", {bus.sdram_wr_req, bus.sdram_rd_req}); end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int n  = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0040;
    step();
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && n < 400) begin
      if (bus.sdram_rd_req) hi++;
      step();
      n++;
    end
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_no_rsp: got %b want 1 within 400 cycles", bus.rsp_valid); end
    n_checks++; if (hi != 256) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 256", hi); end
    n_checks++; if (bus.sdram_rd_req !== 1'b0) begin n_fail++; $display("FAIL to_rd_req_drop: got %b want 0", bus.sdram_rd_req); end
    n_checks++; if (bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_rsp_err: got %b want 1", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== LINE_B) begin n_fail++; $display("FAIL to_rdata_hold: got %h want %h", bus.rsp_rdata, LINE_B); end
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 3'b001) begin n_fail++; $display("FAIL to_after: got %b want 001", {bus.rsp_valid, bus.rsp_err, bus.req_ready}); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0100;
    bus.req_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    step();
    bus.req_valid = 1'b0; bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0; bus.sdram_wr_data_req = 1'b1;
    repeat (3) step();
    n_checks++; if (bus.sdram_wr_data !== 16'h4444) begin n_fail++; $display("FAIL rm_beat3: got %h want 4444", bus.sdram_wr_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.sdram_wr_data !== 16'h0) begin n_fail++; $display("FAIL rm_wr_data: got %h want 0", bus.sdram_wr_data); end
    n_checks++; if (bus.sdram_addr !== 24'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 0", bus.sdram_addr); end
    n_checks++; if (bus.rsp_rdata !== 128'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", bus.rsp_rdata); end
    n_checks++; if ({bus.req_ready, bus.rsp_valid, bus.sdram_wr_req} !== 3'b100) begin n_fail++; $display("FAIL rm_ctrl: got %b want 100", {bus.req_ready, bus.rsp_valid, bus.sdram_wr_req}); end
    bus.sdram_wr_data_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rm_no_rsp: got %b want 10", {bus.req_ready, bus.rsp_valid}); end
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0300;
    step();
    bus.req_valid = 1'b0; bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0; bus.sdram_rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.sdram_rd_data = 16'(16'hC000 + i);
      step();
    end
    bus.sdram_rd_valid = 1'b0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL rm_next_rsp: got %b want 10", {bus.rsp_valid, bus.rsp_err}); end
    n_checks++; if (bus.rsp_rdata !== LINE_C) begin n_fail++; $display("FAIL rm_next_rdata: got %h want %h", bus.rsp_rdata, LINE_C); end
    step();
  endtask

  task automatic test_back_to_back();
    int rsp_k  = -1;
    int acc_k  = -1;
    int pulses = 0;
    int n      = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0200;
    bus.req_wdata = 128'hF0F1_F2F3_F4F5_F6F7_F8F9_FAFB_FCFD_FEFF;
    bus.sdram_ack = 1'b1; bus.sdram_wr_data_req = 1'b1;
    step();
    bus.req_wdata = 128'h1357_9BDF_0000_1111_2222_3333_4444_5555;
    n_checks++; if (bus.sdram_wr_req !== 1'b1) begin n_fail++; $display("FAIL bb_first_req: got %b want 1", bus.sdram_wr_req); end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        n_checks++; if (bus.sdram_wr_data !== 16'hF0F1) begin n_fail++; $display("FAIL bb_first_beat: got %h want F0F1", bus.sdram_wr_data); end
      end
      if (bus.rsp_valid) begin
        pulses++;
        if (rsp_k < 0) rsp_k = k;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bb_ready_in_done: got %b want 0", bus.req_ready); end
      end
      if (bus.sdram_wr_req) begin
        acc_k = k;
        break;
      end
    end
    bus.req_valid = 1'b0;
    n_checks++; if (rsp_k != 9) begin n_fail++; $display("FAIL bb_rsp_cycle: got %0d want 9", rsp_k); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bb_rsp_pulses: got %0d want 1", pulses); end
    n_checks++; if (acc_k != 11) begin n_fail++; $display("FAIL bb_second_accept: got %0d want 11", acc_k); end
    n_checks++; if (bus.sdram_wr_data !== 16'h1357) begin n_fail++; $display("FAIL bb_second_beat: got %h want 1357", bus.sdram_wr_data); end
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL bb_second_rsp: got %b want 10", {bus.rsp_valid, bus.rsp_err}); end
    bus.sdram_ack = 1'b0; bus.sdram_wr_data_req = 1'b0;
    step();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bb_idle: got %b want 1", bus.req_ready); end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_refill();
    test_ignored();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
